// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync/blank/RGB registered outputs plus an
// early pixel request so pipelined content sources line up with active video.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RGB_W    = 24,
    parameter int REQ_LEAD = 1,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [RGB_W-1:0] pixel_data,
    output logic             pixel_req,
    output logic [XW-1:0]    pixel_xpos,
    output logic [YW-1:0]    pixel_ypos,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blk,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int H_END   = H_START + H_DISP;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_DISP;
    localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic [HCW-1:0] h_cnt_reg, h_cnt_next;
    logic [VCW-1:0] v_cnt_reg, v_cnt_next;

    logic             hs_reg, hs_next;
    logic             vs_reg, vs_next;
    logic             blk_reg, blk_next;
    logic [RGB_W-1:0] rgb_reg, rgb_next;
    logic             fs_reg, fs_next;
    logic             ls_reg, ls_next;

    // Signed copies of the counters keep every range compare free of unsigned corner cases.
    int h_pos;
    int v_pos;
    assign h_pos = int'(h_cnt_reg);
    assign v_pos = int'(v_cnt_reg);

    logic h_last, v_last;
    logic h_act, v_act, act;
    logic h_req;

    assign h_last = (h_pos == H_TOTAL - 1);
    assign v_last = (v_pos == V_TOTAL - 1);
    assign h_act  = (h_pos >= H_START) && (h_pos < H_END);
    assign v_act  = (v_pos >= V_START) && (v_pos < V_END);
    assign act    = h_act && v_act;
    assign h_req  = (h_pos >= H_START - REQ_LEAD) && (h_pos < H_END - REQ_LEAD);

    assign pixel_req  = en && v_act && h_req;
    assign pixel_xpos = pixel_req ? XW'(h_pos + REQ_LEAD - H_START) : '0;
    assign pixel_ypos = pixel_req ? YW'(v_pos - V_START) : '0;

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (!en) begin
            h_cnt_next = '0;
            v_cnt_next = '0;
        end else if (h_last) begin
            h_cnt_next = '0;
            v_cnt_next = v_last ? '0 : v_cnt_reg + VCW'(1);
        end else begin
            h_cnt_next = h_cnt_reg + HCW'(1);
        end
    end

    // pixel_data arriving now belongs to the request made REQ_LEAD cycles ago,
    // which is exactly the pixel at the current counter position.
    always_comb begin
        hs_next  = !HS_ACT;
        vs_next  = !VS_ACT;
        blk_next = 1'b0;
        rgb_next = '0;
        fs_next  = 1'b0;
        ls_next  = 1'b0;
        if (en) begin
            hs_next  = (h_pos < H_SYNC) ? HS_ACT : !HS_ACT;
            vs_next  = (v_pos < V_SYNC) ? VS_ACT : !VS_ACT;
            blk_next = act;
            rgb_next = act ? pixel_data : '0;
            ls_next  = (h_cnt_reg == '0);
            fs_next  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
            hs_reg    <= !HS_ACT;
            vs_reg    <= !VS_ACT;
            blk_reg   <= 1'b0;
            rgb_reg   <= '0;
            fs_reg    <= 1'b0;
            ls_reg    <= 1'b0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
            hs_reg    <= hs_next;
            vs_reg    <= vs_next;
            blk_reg   <= blk_next;
            rgb_reg   <= rgb_next;
            fs_reg    <= fs_next;
            ls_reg    <= ls_next;
        end
    end

    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign vga_blk     = blk_reg;
    assign vga_rgb     = rgb_reg;
    assign frame_start = fs_reg;
    assign line_start  = ls_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-timing instance with REQ_LEAD=2 and enable drops,
// and an 800x600 positive-polarity instance with REQ_LEAD=0, both against a frame-position model.
module tb_vga_timing_gen;

    // Instance A: compact timing so several whole frames fit in the run.
    localparam int A_HSY = 5,  A_HBK = 4,  A_HDS = 16, A_HFP = 3;
    localparam int A_VSY = 2,  A_VBK = 3,  A_VDS = 6,  A_VFP = 2;
    localparam int A_HT  = A_HSY + A_HBK + A_HDS + A_HFP;
    localparam int A_VT  = A_VSY + A_VBK + A_VDS + A_VFP;
    localparam int A_HST = A_HSY + A_HBK;
    localparam int A_VST = A_VSY + A_VBK;
    localparam int A_LEAD = 2;

    // Instance B: 800x600 timing, active-high syncs.
    localparam int B_HSY = 128, B_HBK = 88, B_HDS = 800, B_HFP = 40;
    localparam int B_VSY = 4,   B_VBK = 23, B_VDS = 600, B_VFP = 1;
    localparam int B_HT  = B_HSY + B_HBK + B_HDS + B_HFP;
    localparam int B_VT  = B_VSY + B_VBK + B_VDS + B_VFP;
    localparam int B_HST = B_HSY + B_HBK;
    localparam int B_VST = B_VSY + B_VBK;

    localparam int N_CYC = 7000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b;
    logic [23:0] pd_a, pd_b;
    logic [3:0]  tag_a, tag_b;

    logic        req_a, hs_a, vs_a, blk_a, fs_a, ls_a;
    logic [9:0]  xa, ya;
    logic [23:0] rgb_a;
    logic        req_b, hs_b, vs_b, blk_b, fs_b, ls_b;
    logic [9:0]  xb, yb;
    logic [23:0] rgb_b;

    // With zero lead the content source answers in the same cycle.
    assign pd_b = {tag_b, xb, yb};

    vga_timing_gen #(
        .H_SYNC(A_HSY), .H_BACK(A_HBK), .H_DISP(A_HDS), .H_FRONT(A_HFP),
        .V_SYNC(A_VSY), .V_BACK(A_VBK), .V_DISP(A_VDS), .V_FRONT(A_VFP),
        .HS_POL(0), .VS_POL(0), .RGB_W(24), .REQ_LEAD(A_LEAD), .XW(10), .YW(10)
    ) dut_a (
        .vga_clk(clk), .sys_rst_n(rst_n), .en(en_a), .pixel_data(pd_a),
        .pixel_req(req_a), .pixel_xpos(xa), .pixel_ypos(ya),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blk(blk_a), .vga_rgb(rgb_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_gen #(
        .H_SYNC(B_HSY), .H_BACK(B_HBK), .H_DISP(B_HDS), .H_FRONT(B_HFP),
        .V_SYNC(B_VSY), .V_BACK(B_VBK), .V_DISP(B_VDS), .V_FRONT(B_VFP),
        .HS_POL(1), .VS_POL(1), .RGB_W(24), .REQ_LEAD(0), .XW(10), .YW(10)
    ) dut_b (
        .vga_clk(clk), .sys_rst_n(rst_n), .en(en_b), .pixel_data(pd_b),
        .pixel_req(req_b), .pixel_xpos(xb), .pixel_ypos(yb),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blk(blk_b), .vga_rgb(rgb_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    // Model state: cycles elapsed since each generator was last at (0,0).
    int t_a, t_b;
    int ha, va, hb, vb;
    logic [19:0] hist0, hist1;
    logic        e_hs_a, e_vs_a, e_blk_a, e_fs_a, e_ls_a;
    logic [23:0] e_rgb_a;
    logic        e_hs_b, e_vs_b, e_blk_b, e_fs_b, e_ls_b;
    logic [23:0] e_rgb_b;
    logic        r_a, r_b, act_a, act_b;
    int d0, len0, d1, len1, d2;
    int last_ls_b, last_fs_a, quiet_after;

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        pd_a  = '0;
        tag_a = '0;
        tag_b = '0;
        hist0 = '0;
        hist1 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs_a",  -1, 32'(hs_a),  32'd1);
        chk("rst_vs_a",  -1, 32'(vs_a),  32'd1);
        chk("rst_blk_a", -1, 32'(blk_a), 32'd0);
        chk("rst_rgb_a", -1, 32'(rgb_a), 32'd0);
        chk("rst_req_a", -1, 32'(req_a), 32'd0);
        chk("rst_fs_a",  -1, 32'(fs_a),  32'd0);
        chk("rst_ls_a",  -1, 32'(ls_a),  32'd0);
        chk("rst_hs_b",  -1, 32'(hs_b),  32'd0);
        chk("rst_vs_b",  -1, 32'(vs_b),  32'd0);
        chk("rst_blk_b", -1, 32'(blk_b), 32'd0);
        chk("rst_rgb_b", -1, 32'(rgb_b), 32'd0);
        chk("rst_req_b", -1, 32'(req_b), 32'd0);
        $display("reset state checked");
        rst_n = 1'b1;

        // Directed drop mid-active, then a random long drop and a random 1-cycle drop.
        d0   = A_HT * (A_VST + 2) + 7;
        len0 = 50;
        d1   = int'($urandom_range(900, 2500));
        len1 = int'($urandom_range(1, 40));
        d2   = int'($urandom_range(3000, 4000));
        quiet_after = d2 + 1;
        last_ls_b = -1;
        last_fs_a = -1;
        t_a = 0;
        t_b = 0;

        for (int k = 0; k < N_CYC; k++) begin
            en_a  = !((k >= d0 && k < d0 + len0) || (k >= d1 && k < d1 + len1) || (k == d2));
            tag_a = 4'($urandom);
            tag_b = 4'($urandom);
            if (k == d0 || k == d1 || k == d2)
                $display("enable dropped at cycle %0d", k);
            #1;

            ha = t_a % A_HT;
            va = (t_a / A_HT) % A_VT;
            hb = t_b % B_HT;
            vb = (t_b / B_HT) % B_VT;

            r_a = en_a && va >= A_VST && va < A_VST + A_VDS
                  && ha >= A_HST - A_LEAD && ha < A_HST + A_HDS - A_LEAD;
            chk("req_a",  k, 32'(req_a), 32'(r_a));
            chk("xpos_a", k, 32'(xa), r_a ? 32'(ha + A_LEAD - A_HST) : 32'd0);
            chk("ypos_a", k, 32'(ya), r_a ? 32'(va - A_VST) : 32'd0);

            r_b = vb >= B_VST && vb < B_VST + B_VDS && hb >= B_HST && hb < B_HST + B_HDS;
            chk("req_b",  k, 32'(req_b), 32'(r_b));
            chk("xpos_b", k, 32'(xb), r_b ? 32'(hb - B_HST) : 32'd0);
            chk("ypos_b", k, 32'(yb), r_b ? 32'(vb - B_VST) : 32'd0);

            // Content source for A: answer each request two cycles later.
            pd_a  = {tag_a, hist1};
            hist1 = hist0;
            hist0 = {xa, ya};

            act_a   = en_a && va >= A_VST && va < A_VST + A_VDS && ha >= A_HST && ha < A_HST + A_HDS;
            e_hs_a  = en_a ? (ha >= A_HSY) : 1'b1;
            e_vs_a  = en_a ? (va >= A_VSY) : 1'b1;
            e_blk_a = act_a;
            e_rgb_a = act_a ? {tag_a, 10'(ha - A_HST), 10'(va - A_VST)} : 24'd0;
            e_ls_a  = en_a && ha == 0;
            e_fs_a  = en_a && ha == 0 && va == 0;

            act_b   = r_b;
            e_hs_b  = (hb < B_HSY);
            e_vs_b  = (vb < B_VSY);
            e_blk_b = act_b;
            e_rgb_b = act_b ? {tag_b, 10'(hb - B_HST), 10'(vb - B_VST)} : 24'd0;
            e_ls_b  = (hb == 0);
            e_fs_b  = (hb == 0 && vb == 0);

            t_a = en_a ? (t_a + 1) % (A_HT * A_VT) : 0;
            t_b = (t_b + 1) % (B_HT * B_VT);

            @(posedge clk);
            #1;
            chk("hs_a",  k, 32'(hs_a),  32'(e_hs_a));
            chk("vs_a",  k, 32'(vs_a),  32'(e_vs_a));
            chk("blk_a", k, 32'(blk_a), 32'(e_blk_a));
            chk("rgb_a", k, 32'(rgb_a), 32'(e_rgb_a));
            chk("ls_a",  k, 32'(ls_a),  32'(e_ls_a));
            chk("fs_a",  k, 32'(fs_a),  32'(e_fs_a));
            chk("hs_b",  k, 32'(hs_b),  32'(e_hs_b));
            chk("vs_b",  k, 32'(vs_b),  32'(e_vs_b));
            chk("blk_b", k, 32'(blk_b), 32'(e_blk_b));
            chk("rgb_b", k, 32'(rgb_b), 32'(e_rgb_b));
            chk("ls_b",  k, 32'(ls_b),  32'(e_ls_b));
            chk("fs_b",  k, 32'(fs_b),  32'(e_fs_b));

            if (ls_b) begin
                if (last_ls_b >= 0)
                    chk("line_period_b", k, 32'(k - last_ls_b), 32'(B_HT));
                last_ls_b = k;
            end
            if (fs_a) begin
                $display("frame_start a at cycle %0d", k);
                if (last_fs_a > quiet_after)
                    chk("frame_period_a", k, 32'(k - last_fs_a), 32'(A_HT * A_VT));
                last_fs_a = k;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator replacing the fixed 640x480 driver used by the character-display top level. It sits between the PLL-derived pixel clock domain and a display/content module. It produces sync, blanking and registered RGB outputs for any timing set. It also issues pixel requests a configurable number of cycles early, so that pipelined content sources (ROM lookups, font tables) line up with the active window. It adds an enable input, selectable sync polarity and frame/line start strobes.

## Interface
- H_SYNC, 96: horizontal sync width, pixels
- H_BACK, 48: horizontal back porch
- H_DISP, 640: horizontal active width
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: vertical sync width, lines
- V_BACK, 33: vertical back porch
- V_DISP, 480: vertical active height
- V_FRONT, 10: vertical front porch
- HS_POL, 0: hsync active level (0 = active low)
- VS_POL, 0: vsync active level
- RGB_W, 24: vga_rgb / pixel_data width
- REQ_LEAD, 1: pixel_req lead in cycles (0..3); requires H_SYNC+H_BACK ≥ REQ_LEAD
- XW, 10 / YW, 10: coordinate widths

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- en  in  1  timing enable
- pixel_data  in  RGB_W  pixel colour from content source
- pixel_req  out  1  content request (combinational from counters)
- pixel_xpos  out  XW  requested column, 0 when pixel_req low
- pixel_ypos  out  YW  requested row, 0 when pixel_req low
- vga_hs  out  1  registered hsync
- vga_vs  out  1  registered vsync
- vga_blk  out  1  registered active-video flag (1 = visible)
- vga_rgb  out  RGB_W  registered pixel, 0 outside active video
- frame_start  out  1  registered 1-cycle pulse, first cycle of each frame
- line_start  out  1  registered 1-cycle pulse, first cycle of each line

## Operation
- Constants:
  - H_TOTAL = sum of the H params; V_TOTAL = sum of the V params.
  - H_START = H_SYNC+H_BACK; H_END = H_START+H_DISP.
  - V_START and V_END are defined in the same way.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1). Region order is sync, back porch, active, front porch.
- Counter stepping:
  - h_cnt wraps to 0 after H_TOTAL-1.
  - v_cnt increments on each h wrap and wraps to 0 after V_TOTAL-1 on the same cycle.
- en low: counters held at 0 (synchronous clear). All registered outputs go inactive on the next edge:
  - hs = !HS_POL, vs = !VS_POL
  - blk = 0, rgb = 0
  - strobes 0
- With en high, the first frame starts at (0,0).
- Derived signals:
  - act = (H_START ≤ h_cnt < H_END) and (V_START ≤ v_cnt < V_END).
  - pixel_req = en and v in the active range and (H_START-REQ_LEAD ≤ h_cnt < H_END-REQ_LEAD).
  - When requesting, pixel_xpos = h_cnt+REQ_LEAD-H_START and pixel_ypos = v_cnt-V_START.
- Contract: the content source returns the pixel for a request REQ_LEAD cycles later, on pixel_data.
- Registered outputs, from the counter state of the previous cycle:
  - vga_hs = (h_cnt < H_SYNC) ? HS_POL : !HS_POL.
  - vga_vs is defined the same way on v_cnt.
  - vga_blk = act.
  - vga_rgb = act ? pixel_data : 0.
- Strobes:
  - line_start registers (en and h_cnt==0).
  - frame_start registers (en and h_cnt==0 and v_cnt==0).
- Arithmetic: counters are sized to hold H_TOTAL-1 / V_TOTAL-1. Coordinates are truncated to XW/YW.

## Timing
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0
  - vga_hs = !HS_POL, vga_vs = !VS_POL
  - vga_blk = 0, vga_rgb = 0
  - frame_start = line_start = 0
- Latencies:
  - Counter state to sync/blk/rgb: 1 cycle.
  - pixel_req to matching vga_rgb: REQ_LEAD+1 cycles.
- REQ_LEAD=0: pixel_req coincides with act; pixel_data is sampled in the same cycle.
- en deassert mid-frame: outputs are inactive on the next edge. Re-assert restarts at (0,0); frame_start pulses 1 cycle later.
- The frame period is exactly H_TOTAL*V_TOTAL cycles (420000 for the defaults).

## Test plan
- Reset defaults:
  - Stimulus: sys_rst_n low, en=1.
  - Required: hs=1, vs=1, blk=0, rgb=0, pixel_req=0.
  - After release: first edge gives hs=0 and frame_start=1 for exactly 1 cycle.
- Horizontal timing (defaults):
  - vga_hs is low for 96 cycles of every 800.
  - vga_blk is high for 640 cycles, rising 144 cycles after hs falls.
  - line_start period is 800.
- Vertical timing:
  - vga_vs is low for 2 lines (1600 cycles).
  - blk is active on lines 35..514.
  - frame_start recurs every 420000 cycles.
- Request alignment, REQ_LEAD=2:
  - Stimulus: content model returns pixel_data = {xpos,ypos} after 2 cycles.
  - Required: first visible vga_rgb = (0,0) and last = (639,479).
  - pixel_req is first high at h_cnt=142.
- Enable control:
  - Stimulus: drop en at v_cnt=200, hold 50 cycles, re-raise.
  - Required: next cycle hs=vs=1 and blk=0.
  - After re-raise: frame_start pulses and timing restarts from (0,0).
- Polarity/size override:
  - Stimulus: HS_POL=VS_POL=1 with 800x600 timing (128/88/800/40, 4/23/600/1).
  - Required: hs is high for 128 of 1056 cycles; vs is high for 4 lines of 628.
